pipelined_barrel_shifter: RTL and testbench

//  Parametrised, pipelined barrel shifter supporting LSL/LSR/ASR/ROR with a

---
 rtl/pipelined_barrel_shifter_pkg.sv | 11 +
 rtl/pipelined_barrel_shifter_if.sv | 29 ++
 rtl/pipelined_barrel_shifter_stage.sv | 50 +++++
 rtl/pipelined_barrel_shifter.sv | 100 ++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared shift-mode encoding for the pipelined barrel shifter and ALU decode.
package pipelined_barrel_shifter_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2,
    SH_ROR = 2'd3
  } shift_mode_t;

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Operand/result valid-ready bus of the pipelined barrel shifter.
interface pipelined_barrel_shifter_if
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) ();

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  shift_mode_t        in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_carry;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_carry
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_carry
  );

endinterface

// File: rtl/pipelined_barrel_shifter_stage.sv
// One mux layer of the barrel shifter: optional shift by DIST in the given
// mode, replacing the carry with the last bit shifted out.
module shift_stage
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             carry_i,
  input  shift_mode_t      mode_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] data_o,
  output logic             carry_o
);

  // Shift and carry select for this layer's distance
  always_comb begin
    data_o  = data_i;
    carry_o = carry_i;
    if (en_i) begin
      case (mode_i)
        SH_LSL: begin
          data_o  = data_i << DIST;
          carry_o = data_i[WIDTH-DIST];
        end
        SH_LSR: begin
          data_o  = data_i >> DIST;
          carry_o = data_i[DIST-1];
        end
        SH_ASR: begin
          data_o  = $signed(data_i) >>> DIST;
          carry_o = data_i[DIST-1];
        end
        SH_ROR: begin
          data_o  = (data_i >> DIST) | (data_i << (WIDTH - DIST));
          carry_o = data_i[DIST-1];
        end
        default: begin
          data_o  = data_i;
          carry_o = carry_i;
        end
      endcase
    end else begin
      data_o  = data_i;
      carry_o = carry_i;
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Elastic barrel shifter: stage k applies shift bit k and registers the
// result, giving SHAMT_W cycles of latency at one operation per cycle.
module pipelined_barrel_shifter
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic                       clk,
  input logic                       rst,
  pipelined_barrel_shifter_if.slave bus
);

  logic [SHAMT_W-1:0] v_s;
  logic [SHAMT_W-1:0] ld_s;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    // Shift-amount bits still to be applied from this stage onwards
    localparam int RW = SHAMT_W - k;

    logic              up_v_s;
    logic [WIDTH-1:0]  up_data_s;
    logic              up_carry_s;
    logic [RW-1:0]     up_shamt_s;
    shift_mode_t       up_mode_s;
    logic [WIDTH-1:0]  data_d;
    logic              carry_d;
    logic              v_q;
    logic [WIDTH-1:0]  data_q;
    logic              carry_q;

    if (k == 0) begin : g_src
      assign up_v_s     = bus.in_valid;
      assign up_data_s  = bus.in_data;
      assign up_carry_s = 1'b0;
      assign up_shamt_s = bus.in_shamt;
      assign up_mode_s  = bus.in_mode;
    end else begin : g_src
      assign up_v_s     = g_stage[k-1].v_q;
      assign up_data_s  = g_stage[k-1].data_q;
      assign up_carry_s = g_stage[k-1].carry_q;
      assign up_shamt_s = g_stage[k-1].g_fwd.shamt_q;
      assign up_mode_s  = g_stage[k-1].g_fwd.mode_q;
    end

    // A stage may load when any stage from here to the output has a free slot
    // or the output is being drained this cycle.
    assign v_s[k]  = v_q;
    assign ld_s[k] = bus.out_ready | ~(&v_s[SHAMT_W-1:k]);

    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_shift_stage (
      .data_i  (up_data_s),
      .carry_i (up_carry_s),
      .mode_i  (up_mode_s),
      .en_i    (up_shamt_s[0]),
      .data_o  (data_d),
      .carry_o (carry_d)
    );

    // Stage result registers; payload only captured for a valid operation
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q     <= 1'b0;
        data_q  <= '0;
        carry_q <= 1'b0;
      end else if (ld_s[k]) begin
        v_q <= up_v_s;
        if (up_v_s) begin
          data_q  <= data_d;
          carry_q <= carry_d;
        end
      end
    end

    if (k < SHAMT_W - 1) begin : g_fwd
      logic [RW-2:0] shamt_q;
      shift_mode_t   mode_q;

      // Control carried forward to the remaining stages
      always_ff @(posedge clk) begin
        if (rst) begin
          shamt_q <= '0;
          mode_q  <= SH_LSL;
        end else if (ld_s[k] && up_v_s) begin
          shamt_q <= up_shamt_s[RW-1:1];
          mode_q  <= up_mode_s;
        end
      end
    end
  end

  assign bus.in_ready  = ld_s[0];
  assign bus.out_valid = g_stage[SHAMT_W-1].v_q;
  assign bus.out_data  = g_stage[SHAMT_W-1].data_q;
  assign bus.out_carry = g_stage[SHAMT_W-1].carry_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench: directed cases plus a randomised sweep, scored against
// a bit-level reference model of the shift rules.
module tb_pipelined_barrel_shifter;
  import pipelined_barrel_shifter_pkg::*;

  localparam int WIDTH   = 8;
  localparam int SHAMT_W = 3;

  typedef struct {
    logic [7:0] d;
    logic       c;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_barrel_shifter_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

  pipelined_barrel_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   n_in   = 0;
  int   n_out  = 0;
  bit   lat_chk  = 1'b0;
  bit   last_acc = 1'b0;

  // Returns {carry, data}, built bit by bit from the shift definitions
  function automatic logic [8:0] ref_shift(input logic [7:0] d, input int s, input int m);
    logic [7:0] r;
    logic       c;
    for (int i = 0; i < 8; i++) begin
      case (m)
        0: if (i - s >= 0) r[i] = d[i-s]; else r[i] = 1'b0;
        1: if (i + s < 8)  r[i] = d[i+s]; else r[i] = 1'b0;
        2: if (i + s < 8)  r[i] = d[i+s]; else r[i] = d[7];
        default: r[i] = d[(i+s)%8];
      endcase
    end
    c = 1'b0;
    if (s != 0) begin
      case (m)
        0: c = d[8-s];
        3: c = r[7];
        default: c = d[s-1];
      endcase
    end
    return {c, r};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: observe at the falling edge, then step past the rising edge
  task automatic cycle();
    logic [8:0] r;
    @(negedge clk);
    last_acc = 1'b0;
    if (!rst) begin
      check_eq("in_ready", bus.in_ready, bus.out_ready || sb.size() < 3);
      if (sb.size() == 0) begin
        check_eq("idle_out_valid", bus.out_valid, 0);
      end else if (bus.out_valid) begin
        check_eq("out_data", bus.out_data, sb[0].d);
        check_eq("out_carry", bus.out_carry, sb[0].c);
        if (bus.out_ready) begin
          if (lat_chk) check_eq("latency", cyc - sb[0].acc, 3);
          void'(sb.pop_front());
          n_out++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        r = ref_shift(bus.in_data, int'(bus.in_shamt), int'(bus.in_mode));
        sb.push_back('{r[7:0], r[8], cyc});
        n_in++;
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [7:0] d, input int s, input int m);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = s[2:0];
    bus.in_mode  = shift_mode_t'(m[1:0]);
    for (int t = 0; t < 50; t++) begin
      cycle();
      if (last_acc) break;
    end
    check_eq("send_accept", last_acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 100; t++) begin
      if (sb.size() == 0) break;
      cycle();
    end
    check_eq("drain_empty", sb.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_out_valid"}, bus.out_valid, 0);
    check_eq({tag, "_in_ready"}, bus.in_ready, 1);
    check_eq({tag, "_out_data"}, bus.out_data, 0);
    check_eq({tag, "_out_carry"}, bus.out_carry, 0);
  endtask

  initial begin
    int i;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_shamt  = 3'd0;
    bus.in_mode   = SH_LSL;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    // Directed results with fixed latency
    lat_chk = 1'b1;
    send(8'hDB, 1, 0);
    send(8'hDB, 1, 1);
    send(8'h90, 3, 2);
    send(8'hDB, 4, 3);
    for (int m = 0; m < 4; m++) send(8'hA5, 0, m);
    drain();

    // Back-to-back walking one
    for (int s = 0; s < 8; s++) send(8'h01, s, 0);
    drain();
    lat_chk = 1'b0;

    // Backpressure window in the middle of a stream
    i = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'($urandom);
    bus.in_shamt = 3'($urandom);
    bus.in_mode  = shift_mode_t'($urandom_range(0, 3));
    for (int t = 0; t < 60 && i < 10; t++) begin
      bus.out_ready = !(t >= 4 && t < 9);
      cycle();
      if (last_acc) begin
        i++;
        bus.in_data  = 8'($urandom);
        bus.in_shamt = 3'($urandom);
        bus.in_mode  = shift_mode_t'($urandom_range(0, 3));
      end
    end
    drain();
    check_eq("stream_count", n_out, n_in);

    // Reset with operations in flight
    send(8'h5A, 2, 0);
    send(8'hC3, 1, 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    sb.delete();
    n_in  = 0;
    n_out = 0;
    check_reset_state("midrst");
    repeat (6) cycle();

    // Randomised sweep with random valid and ready
    for (int t = 0; t < 800; t++) begin
      if (!bus.in_valid || last_acc) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_data  = 8'($urandom);
        bus.in_shamt = 3'($urandom);
        bus.in_mode  = shift_mode_t'($urandom_range(0, 3));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();
    check_eq("random_count", n_out, n_in);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
